array_init_gen: RTL and testbench
=================================

ARRAY_INIT_GEN -- requirements
Module: array_init_gen

Interface
REQ-001 SHALL have parameter ADDR_W, default 8: address width.
REQ-002 SHALL have parameter DATA_W, default 8: data width.
REQ-003 SHALL have parameter DEPTH, default 2**ADDR_W: words to write, legal range 2..2**ADDR_W.
REQ-004 SHALL have port clk  input  1: clock, all logic on rising edge.
REQ-005 SHALL have port reset  input  1: asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1: request a fill run, sampled only in IDLE.
REQ-007 SHALL have port abort  input  1: cancel an in-progress run.
REQ-008 SHALL have port mode  input  2: fill pattern select, latched at start.
REQ-009 SHALL have port fill_value  input  DATA_W: pattern operand, latched at start.
REQ-010 SHALL have port wr_en  output  1: memory write strobe.
REQ-011 SHALL have port address  output  ADDR_W: write address.
REQ-012 SHALL have port data  output  DATA_W: write data.
REQ-013 SHALL have port selector  output  1: memory-port ownership, high in FILL and DRAIN.
REQ-014 SHALL have port busy  output  1: high in any state other than IDLE.
REQ-015 SHALL have port finish  output  1: one-cycle completion pulse.

Function
REQ-016 SHALL implement FSM states IDLE, FILL, DRAIN, DONE.
REQ-017 IDLE -> FILL when start=1 at a clock edge; mode and fill_value captured at that edge; address counter cleared to 0.
REQ-018 In FILL, wr_en=1 every cycle and address increments by 1 per cycle from 0 to DEPTH-1; exactly DEPTH writes per run, no gaps.
REQ-019 FILL -> DRAIN on the cycle address=DEPTH-1; DRAIN lasts exactly one cycle with wr_en=0 and selector=1.
REQ-020 DRAIN -> DONE; DONE lasts one cycle with finish=1, selector=0, busy=1; DONE -> IDLE unconditionally.
REQ-021 Latency: start edge N gives first write in cycle N+1, last write in cycle N+DEPTH, finish in cycle N+DEPTH+2.
REQ-022 Pattern mode 0 (IDENTITY): data = address, zero-extended or truncated to DATA_W.
REQ-023 Pattern mode 1 (CONST): data = latched fill_value.
REQ-024 Pattern mode 2 (DESCEND): data = (DEPTH-1-address), zero-extended or truncated to DATA_W.
REQ-025 Pattern mode 3 (XOR): data = address XOR latched fill_value, with the address zero-extended or truncated to DATA_W.
REQ-026 data and address SHALL be combinational functions of the counter and latched operands; mode/fill_value changes after start have no effect within a run.
REQ-027 start while not IDLE SHALL be ignored, including start held high through DONE; a new run requires start=1 while in IDLE.
REQ-028 abort=1 in FILL or DRAIN SHALL force IDLE at the next edge; no finish pulse; wr_en, selector and busy low from the following cycle.
REQ-029 abort in IDLE or DONE SHALL have no effect; abort and start together in IDLE: abort wins, stay IDLE.
REQ-030 Address counter SHALL never exceed DEPTH-1; no wrap-around write to address 0 within a run.
REQ-031 Outside FILL, address SHALL hold 0 and data SHALL hold the value of the pattern at address 0.

Reset
REQ-032 reset=0 SHALL asynchronously force IDLE, counter=0, latched mode=0, latched fill_value=0.
REQ-033 While reset is low, wr_en, selector, busy and finish SHALL be 0, address SHALL be 0 and data SHALL be 0.
REQ-034 Reset asserted mid-run SHALL discard the run; no finish pulse follows reset release.

Structure
REQ-035 Package array_init_pkg SHALL hold the mode enum (IDENTITY, CONST, DESCEND, XOR) and the state enum.
REQ-036 Address counter SHALL be a sub-module init_addr_counter with clear, enable, terminal-count output, parameterised by ADDR_W and DEPTH.

Verification
REQ-037 Defaults, mode 0, start pulse -> 256 writes with addr 0..255 and data=addr; finish at cycle N+258; selector low at finish.
REQ-038 mode 1, fill_value=8'hA5, DEPTH=16 -> 16 writes of A5 at addr 0..15; no write to addr 16 or 0 after the run.
REQ-039 mode 2, DEPTH=256 -> addr 0 gets data FF, addr 255 gets data 00; mode 3, fill_value=8'h0F -> addr 0x12 gets data 0x1D.
REQ-040 abort at FILL addr=100 -> last write at addr 100 or earlier, IDLE next cycle, no finish; a following start gives a full 256-write run.
REQ-041 reset low at FILL addr=50 -> all outputs 0 immediately; after release, no writes and no finish until a new start.
REQ-042 start held high continuously -> runs back-to-back, each separated by at least one IDLE cycle; mode change mid-run does not alter data.

Source files
------------

// File: rtl/array_init_pkg.sv
// Shared types for the array initialiser.
//   mode_e  : fill pattern selector, latched at the start of each run
//   state_e : sequencer states
package array_init_pkg;

  typedef enum logic [1:0] {
    ModeIdentity = 2'd0,
    ModeConst    = 2'd1,
    ModeDescend  = 2'd2,
    ModeXor      = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFill  = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } state_e;

endpackage

// File: rtl/array_init_gen_if.sv
// Control and memory-write bundle of the array initialiser.
//   master : requester side, drives start/abort/mode/fill_value
//   slave  : initialiser side, drives the write port and status
interface array_init_gen_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
);
  logic              start;
  logic              abort;
  logic [1:0]        mode;
  logic [DATA_W-1:0] fill_value;
  logic              wr_en;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data;
  logic              selector;
  logic              busy;
  logic              finish;

  modport master (
    output start, abort, mode, fill_value,
    input  wr_en, address, data, selector, busy, finish
  );

  modport slave (
    input  start, abort, mode, fill_value,
    output wr_en, address, data, selector, busy, finish
  );
endinterface

// File: rtl/init_addr_counter.sv
// Write-address counter for the array initialiser.
//   clk, reset : clock, asynchronous active-low reset
//   i_clear    : synchronous clear to 0 (wins over i_enable)
//   i_enable   : count up by one; saturates at DEPTH-1
//   o_count    : current address
//   o_tc       : high while the count equals DEPTH-1
module init_addr_counter #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_clear,
  input  logic              i_enable,
  output logic [ADDR_W-1:0] o_count,
  output logic              o_tc
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  logic [ADDR_W-1:0] r_count;
  logic              w_tc;

  assign w_tc = (r_count == LastAddr);

  // Holding at the terminal count keeps the address from wrapping to 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && !w_tc) begin
      r_count <= r_count + ADDR_W'(1);
    end
  end

  assign o_count = r_count;
  assign o_tc    = w_tc;

endmodule

// File: rtl/array_init_gen.sv
// Array initialiser: on start, writes DEPTH consecutive words (address 0..DEPTH-1)
// with a selectable pattern, then idles one drain cycle and pulses finish.
//   clk, reset : clock, asynchronous active-low reset
//   bus.start/abort/mode/fill_value : run control, mode/fill_value latched at start
//   bus.wr_en/address/data          : memory write port
//   bus.selector : memory-port ownership (FILL and DRAIN)
//   bus.busy     : not idle
//   bus.finish   : one-cycle completion pulse
module array_init_gen
  import array_init_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 2 ** ADDR_W
) (
  input logic               clk,
  input logic               reset,
  array_init_gen_if.slave   bus
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  state_e            r_state;
  mode_e             r_mode;
  logic [DATA_W-1:0] r_fill_value;
  logic              r_wr_en;
  logic              r_selector;
  logic              r_busy;
  logic              r_finish;

  logic [ADDR_W-1:0] w_count;
  logic              w_tc;
  logic              w_in_fill;
  logic              w_clear;
  logic [DATA_W-1:0] w_addr_ext;
  logic [DATA_W-1:0] w_desc_ext;
  logic [DATA_W-1:0] w_data;

  assign w_in_fill = (r_state == StFill);
  // Clearing on every exit from FILL keeps the address at 0 everywhere else.
  assign w_clear   = !w_in_fill || w_tc || bus.abort;

  init_addr_counter #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_addr_counter (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (w_clear),
    .i_enable (w_in_fill),
    .o_count  (w_count),
    .o_tc     (w_tc)
  );

  assign w_addr_ext = DATA_W'(w_count);
  assign w_desc_ext = DATA_W'(LastAddr - w_count);

  always_comb begin
    w_data = w_addr_ext;
    unique case (r_mode)
      ModeIdentity: w_data = w_addr_ext;
      ModeConst:    w_data = r_fill_value;
      ModeDescend:  w_data = w_desc_ext;
      ModeXor:      w_data = w_addr_ext ^ r_fill_value;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= StIdle;
      r_mode       <= ModeIdentity;
      r_fill_value <= '0;
      r_wr_en      <= 1'b0;
      r_selector   <= 1'b0;
      r_busy       <= 1'b0;
      r_finish     <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          // Abort beats start when both arrive in IDLE.
          if (bus.start && !bus.abort) begin
            r_state      <= StFill;
            r_mode       <= mode_e'(bus.mode);
            r_fill_value <= bus.fill_value;
            r_wr_en      <= 1'b1;
            r_selector   <= 1'b1;
            r_busy       <= 1'b1;
          end
        end
        StFill: begin
          if (bus.abort) begin
            r_state    <= StIdle;
            r_wr_en    <= 1'b0;
            r_selector <= 1'b0;
            r_busy     <= 1'b0;
          end else if (w_tc) begin
            r_state <= StDrain;
            r_wr_en <= 1'b0;
          end
        end
        StDrain: begin
          if (bus.abort) begin
            r_state    <= StIdle;
            r_selector <= 1'b0;
            r_busy     <= 1'b0;
          end else begin
            r_state    <= StDone;
            r_selector <= 1'b0;
            r_finish   <= 1'b1;
          end
        end
        StDone: begin
          r_state  <= StIdle;
          r_busy   <= 1'b0;
          r_finish <= 1'b0;
        end
        default: begin
          r_state    <= StIdle;
          r_wr_en    <= 1'b0;
          r_selector <= 1'b0;
          r_busy     <= 1'b0;
          r_finish   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.wr_en    = r_wr_en;
  assign bus.address  = w_count;
  assign bus.data     = w_data;
  assign bus.selector = r_selector;
  assign bus.busy     = r_busy;
  assign bus.finish   = r_finish;

endmodule

// File: tb/tb_array_init_gen.sv
// Directed bench: one 256-deep instance (a) and one 16-deep instance (b).
module tb_array_init_gen;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   errors = 0;
  int   checks = 0;

  array_init_gen_if #(.ADDR_W(8), .DATA_W(8)) bus_a ();
  array_init_gen_if #(.ADDR_W(8), .DATA_W(8)) bus_b ();

  array_init_gen #(.ADDR_W(8), .DATA_W(8), .DEPTH(256)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  array_init_gen #(.ADDR_W(8), .DATA_W(8), .DEPTH(16)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  always #5 clk = ~clk;

  // {wr_en, selector, busy, finish}
  function automatic logic [3:0] ctl_a();
    return {bus_a.wr_en, bus_a.selector, bus_a.busy, bus_a.finish};
  endfunction

  function automatic logic [3:0] ctl_b();
    return {bus_b.wr_en, bus_b.selector, bus_b.busy, bus_b.finish};
  endfunction

  task automatic test_reset();
    bus_a.start = 0; bus_a.abort = 0; bus_a.mode = 0; bus_a.fill_value = 0;
    bus_b.start = 0; bus_b.abort = 0; bus_b.mode = 0; bus_b.fill_value = 0;
    reset = 0;
    #2;
    checks++; if (ctl_a() !== 4'b0000) begin errors++; $display("FAIL reset_ctl_a got %b want 0000", ctl_a()); end
    checks++; if (bus_a.address !== 8'h00) begin errors++; $display("FAIL reset_addr_a got %h want 00", bus_a.address); end
    checks++; if (bus_a.data !== 8'h00) begin errors++; $display("FAIL reset_data_a got %h want 00", bus_a.data); end
    checks++; if (ctl_b() !== 4'b0000) begin errors++; $display("FAIL reset_ctl_b got %b want 0000", ctl_b()); end
    @(negedge clk); @(negedge clk);
    reset = 1;
    @(negedge clk);
    checks++; if (ctl_a() !== 4'b0000) begin errors++; $display("FAIL post_reset_ctl_a got %b want 0000", ctl_a()); end
  endtask

  task automatic test_identity();
    logic [7:0] k8;
    @(negedge clk); bus_a.mode = 2'd0; bus_a.fill_value = 8'h3C; bus_a.start = 1;
    @(negedge clk); bus_a.start = 0;   // cycle N+1: first write
    for (int k = 0; k < 256; k++) begin
      k8 = 8'(k);
      checks++;
      if (bus_a.wr_en !== 1'b1 || {bus_a.address, bus_a.data} !== {k8, k8}) begin
        errors++;
        $display("FAIL identity_write k=%0d got we=%b a=%h d=%h want we=1 a=%h d=%h",
                 k, bus_a.wr_en, bus_a.address, bus_a.data, k8, k8);
      end
      @(negedge clk);
    end
    checks++; if (ctl_a() !== 4'b0110) begin errors++; $display("FAIL identity_drain got %b want 0110", ctl_a()); end
    @(negedge clk);  // N+258
    checks++; if (ctl_a() !== 4'b0011) begin errors++; $display("FAIL identity_done got %b want 0011", ctl_a()); end
    @(negedge clk);
    checks++; if (ctl_a() !== 4'b0000) begin errors++; $display("FAIL identity_idle got %b want 0000", ctl_a()); end
    checks++; if (bus_a.address !== 8'h00) begin errors++; $display("FAIL identity_idle_addr got %h want 00", bus_a.address); end
  endtask

  task automatic test_const_depth16();
    logic [7:0] k8;
    int         stray;
    @(negedge clk); bus_b.mode = 2'd1; bus_b.fill_value = 8'hA5; bus_b.start = 1;
    @(negedge clk); bus_b.start = 0;
    for (int k = 0; k < 16; k++) begin
      k8 = 8'(k);
      checks++;
      if (bus_b.wr_en !== 1'b1 || {bus_b.address, bus_b.data} !== {k8, 8'hA5}) begin
        errors++;
        $display("FAIL const_write k=%0d got we=%b a=%h d=%h want we=1 a=%h d=a5",
                 k, bus_b.wr_en, bus_b.address, bus_b.data, k8);
      end
      @(negedge clk);
    end
    checks++; if (ctl_b() !== 4'b0110) begin errors++; $display("FAIL const_drain got %b want 0110", ctl_b()); end
    @(negedge clk);
    checks++; if (ctl_b() !== 4'b0011) begin errors++; $display("FAIL const_done got %b want 0011", ctl_b()); end
    stray = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus_b.wr_en !== 1'b0) stray++;
    end
    checks++; if (stray !== 0) begin errors++; $display("FAIL const_no_extra_write got %0d writes want 0", stray); end
    checks++; if (bus_b.data !== 8'hA5) begin errors++; $display("FAIL const_idle_data got %h want a5", bus_b.data); end
  endtask

  task automatic test_patterns();
    logic [7:0] k8;
    logic [7:0] d_first, d_last, d_12;
    d_first = 8'hxx; d_last = 8'hxx; d_12 = 8'hxx;
    // DESCEND
    @(negedge clk); bus_a.mode = 2'd2; bus_a.fill_value = 8'h00; bus_a.start = 1;
    @(negedge clk); bus_a.start = 0;
    for (int k = 0; k < 256; k++) begin
      k8 = 8'(k);
      if (k == 0) d_first = bus_a.data;
      if (k == 255) d_last = bus_a.data;
      checks++;
      if (bus_a.wr_en !== 1'b1 || {bus_a.address, bus_a.data} !== {k8, 8'(255 - k)}) begin
        errors++;
        $display("FAIL descend_write k=%0d got we=%b a=%h d=%h want we=1 a=%h d=%h",
                 k, bus_a.wr_en, bus_a.address, bus_a.data, k8, 8'(255 - k));
      end
      @(negedge clk);
    end
    checks++; if (d_first !== 8'hFF) begin errors++; $display("FAIL descend_addr0 got %h want ff", d_first); end
    checks++; if (d_last !== 8'h00) begin errors++; $display("FAIL descend_addr255 got %h want 00", d_last); end
    @(negedge clk); @(negedge clk);
    checks++; if ({bus_a.address, bus_a.data} !== 16'h00FF) begin
      errors++; $display("FAIL descend_idle got a=%h d=%h want a=00 d=ff", bus_a.address, bus_a.data);
    end
    // XOR, with operands changed mid-run
    @(negedge clk); bus_a.mode = 2'd3; bus_a.fill_value = 8'h0F; bus_a.start = 1;
    @(negedge clk); bus_a.start = 0;
    for (int k = 0; k < 256; k++) begin
      k8 = 8'(k);
      if (k == 5) begin bus_a.mode = 2'd1; bus_a.fill_value = 8'hFF; end
      if (k == 8'h12) d_12 = bus_a.data;
      checks++;
      if (bus_a.wr_en !== 1'b1 || {bus_a.address, bus_a.data} !== {k8, k8 ^ 8'h0F}) begin
        errors++;
        $display("FAIL xor_write k=%0d got we=%b a=%h d=%h want we=1 a=%h d=%h",
                 k, bus_a.wr_en, bus_a.address, bus_a.data, k8, k8 ^ 8'h0F);
      end
      @(negedge clk);
    end
    checks++; if (d_12 !== 8'h1D) begin errors++; $display("FAIL xor_addr12 got %h want 1d", d_12); end
    @(negedge clk); @(negedge clk);
    checks++; if (ctl_a() !== 4'b0000) begin errors++; $display("FAIL xor_idle got %b want 0000", ctl_a()); end
  endtask

  task automatic test_abort();
    bit found;
    int stray, writes, fins;
    logic [7:0] max_addr;
    // start and abort together in IDLE: stay idle
    @(negedge clk); bus_a.mode = 2'd0; bus_a.start = 1; bus_a.abort = 1;
    @(negedge clk); bus_a.start = 0; bus_a.abort = 0;
    checks++; if (ctl_a() !== 4'b0000) begin errors++; $display("FAIL abort_start_idle got %b want 0000", ctl_a()); end
    // abort at address 100
    bus_a.start = 1;
    @(negedge clk); bus_a.start = 0;
    found = 0;
    for (int c = 0; c < 300 && !found; c++) begin
      if (bus_a.wr_en === 1'b1 && bus_a.address === 8'd100) found = 1;
      else @(negedge clk);
    end
    checks++; if (!found) begin errors++; $display("FAIL abort_reach_100 got timeout want address 100"); end
    bus_a.abort = 1;
    @(negedge clk); bus_a.abort = 0;
    checks++; if (ctl_a() !== 4'b0000) begin errors++; $display("FAIL abort_idle got %b want 0000", ctl_a()); end
    stray = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus_a.wr_en !== 1'b0 || bus_a.finish !== 1'b0) stray++;
    end
    checks++; if (stray !== 0) begin errors++; $display("FAIL abort_quiet got %0d active cycles want 0", stray); end
    // following start gives a full run
    bus_a.start = 1;
    @(negedge clk); bus_a.start = 0;
    writes = 0; fins = 0; max_addr = 0;
    for (int c = 0; c < 270; c++) begin
      if (bus_a.wr_en === 1'b1) begin
        writes++;
        if (bus_a.address > max_addr) max_addr = bus_a.address;
      end
      if (bus_a.finish === 1'b1) fins++;
      @(negedge clk);
    end
    checks++; if (writes !== 256) begin errors++; $display("FAIL abort_rerun_writes got %0d want 256", writes); end
    checks++; if (fins !== 1) begin errors++; $display("FAIL abort_rerun_finish got %0d want 1", fins); end
    checks++; if (max_addr !== 8'hFF) begin errors++; $display("FAIL abort_rerun_maxaddr got %h want ff", max_addr); end
  endtask

  task automatic test_reset_mid_run();
    bit found;
    int stray;
    @(negedge clk); bus_a.mode = 2'd2; bus_a.start = 1;
    @(negedge clk); bus_a.start = 0;
    found = 0;
    for (int c = 0; c < 300 && !found; c++) begin
      if (bus_a.wr_en === 1'b1 && bus_a.address === 8'd50) found = 1;
      else @(negedge clk);
    end
    checks++; if (!found) begin errors++; $display("FAIL rst_reach_50 got timeout want address 50"); end
    #2 reset = 0;
    #1;
    checks++; if (ctl_a() !== 4'b0000) begin errors++; $display("FAIL rst_mid_ctl got %b want 0000", ctl_a()); end
    checks++; if ({bus_a.address, bus_a.data} !== 16'h0000) begin
      errors++; $display("FAIL rst_mid_bus got a=%h d=%h want 0000", bus_a.address, bus_a.data);
    end
    @(negedge clk); reset = 1;
    stray = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus_a.wr_en !== 1'b0 || bus_a.finish !== 1'b0) stray++;
    end
    checks++; if (stray !== 0) begin errors++; $display("FAIL rst_quiet got %0d active cycles want 0", stray); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] k8;
    @(negedge clk); bus_a.mode = 2'd0; bus_a.fill_value = 8'h00; bus_a.start = 1;
    @(negedge clk);
    for (int k = 0; k < 256; k++) begin
      k8 = 8'(k);
      if (k == 10) begin bus_a.mode = 2'd3; bus_a.fill_value = 8'h0F; end
      checks++;
      if (bus_a.wr_en !== 1'b1 || {bus_a.address, bus_a.data} !== {k8, k8}) begin
        errors++;
        $display("FAIL b2b_write k=%0d got we=%b a=%h d=%h want we=1 a=%h d=%h",
                 k, bus_a.wr_en, bus_a.address, bus_a.data, k8, k8);
      end
      @(negedge clk);
    end
    checks++; if (ctl_a() !== 4'b0110) begin errors++; $display("FAIL b2b_drain got %b want 0110", ctl_a()); end
    @(negedge clk);
    checks++; if (ctl_a() !== 4'b0011) begin errors++; $display("FAIL b2b_done got %b want 0011", ctl_a()); end
    @(negedge clk);
    checks++; if (ctl_a() !== 4'b0000) begin errors++; $display("FAIL b2b_idle_gap got %b want 0000", ctl_a()); end
    @(negedge clk);
    checks++; if (bus_a.wr_en !== 1'b1 || {bus_a.address, bus_a.data} !== 16'h000F) begin
      errors++; $display("FAIL b2b_second_run got we=%b a=%h d=%h want we=1 a=00 d=0f",
                         bus_a.wr_en, bus_a.address, bus_a.data);
    end
    bus_a.start = 0; bus_a.abort = 1;
    @(negedge clk); bus_a.abort = 0;
    checks++; if (ctl_a() !== 4'b0000) begin errors++; $display("FAIL b2b_abort got %b want 0000", ctl_a()); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_identity();
    test_const_depth16();
    test_patterns();
    test_abort();
    test_reset_mid_run();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
